// File: rtl/load_store_queue.sv
// load_store_queue: in-order memory-op queue for an out-of-order core.
// Entries are allocated at the tail, woken up by result broadcasts and
// issued strictly in order from the head (loads when the address is known
// and memory is ready, stores when the ROB commits them).
// Build option: define LSQ_MMIO_STRICT_EN to hold loads at or above
// MMIO_BASE until they are the oldest ROB entry and the IO path has room.
module load_store_queue #(
  parameter int          DEPTH     = 8,
  parameter int          CDB_N     = 2,
  parameter int          XLEN      = 32,
  parameter int          ROB_W     = 4,
  parameter logic [31:0] MMIO_BASE = 32'h30000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic                   flush,
  input  logic                   alloc_valid,
  output logic                   alloc_ready,
  input  logic                   alloc_store,
  input  logic [2:0]             alloc_funct3,
  input  logic [ROB_W-1:0]       alloc_rob_id,
  input  logic                   alloc_q1_rdy,
  input  logic                   alloc_q2_rdy,
  input  logic [ROB_W-1:0]       alloc_q1,
  input  logic [ROB_W-1:0]       alloc_q2,
  input  logic [XLEN-1:0]        alloc_v1,
  input  logic [XLEN-1:0]        alloc_v2,
  input  logic [XLEN-1:0]        alloc_imm,
  input  logic [CDB_N-1:0]       cdb_valid,
  input  logic [CDB_N*ROB_W-1:0] cdb_tag,
  input  logic [CDB_N*XLEN-1:0]  cdb_data,
  input  logic                   commit_store,
  input  logic [ROB_W-1:0]       rob_head_id,
  input  logic                   io_full,
  input  logic                   mem_ready,
  output logic                   mem_req_valid,
  output logic                   mem_req_store,
  output logic [2:0]             mem_req_funct3,
  output logic [XLEN-1:0]        mem_req_addr,
  output logic [XLEN-1:0]        mem_req_data,
  output logic [ROB_W-1:0]       mem_req_id,
  output logic                   head_valid,
  output logic                   head_store,
  output logic [ROB_W-1:0]       head_id,
  output logic                   head_ready,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]    head, tail;
  logic [DEPTH-1:0] e_valid, e_store, e_addr_rdy, e_data_rdy;
  logic [2:0]       e_funct3 [DEPTH];
  logic [ROB_W-1:0] e_id     [DEPTH];
  logic [ROB_W-1:0] e_q1     [DEPTH];
  logic [ROB_W-1:0] e_q2     [DEPTH];
  logic [XLEN-1:0]  e_imm    [DEPTH];
  logic [XLEN-1:0]  e_addr   [DEPTH];
  logic [XLEN-1:0]  e_data   [DEPTH];

  // Any live broadcast carrying this tag?
  function automatic logic cdb_hit(input logic [ROB_W-1:0] tag);
    cdb_hit = 1'b0;
    for (int k = 0; k < CDB_N; k++)
      if (cdb_valid[k] && cdb_tag[k*ROB_W +: ROB_W] == tag) cdb_hit = 1'b1;
  endfunction

  // Value for this tag; scanning downwards lets the lowest channel win.
  function automatic logic [XLEN-1:0] cdb_val(input logic [ROB_W-1:0] tag);
    cdb_val = '0;
    for (int k = CDB_N - 1; k >= 0; k--)
      if (cdb_valid[k] && cdb_tag[k*ROB_W +: ROB_W] == tag)
        cdb_val = cdb_data[k*XLEN +: XLEN];
  endfunction

  logic [DEPTH-1:0] w1_hit, w2_hit;
  logic [XLEN-1:0]  w1_data [DEPTH];
  logic [XLEN-1:0]  w2_data [DEPTH];

  // Per-entry wakeup match against the broadcast bus.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w1_hit[i]  = cdb_hit(e_q1[i]);
      w1_data[i] = cdb_val(e_q1[i]);
      w2_hit[i]  = cdb_hit(e_q2[i]);
      w2_data[i] = cdb_val(e_q2[i]);
    end
  end

  logic            base_rdy, data_rdy;
  logic [XLEN-1:0] base_val, data_val;

  // Operands of the incoming op, including same-cycle broadcast bypass.
  // Loads carry no data operand, so their data side is born ready.
  always_comb begin
    base_rdy = alloc_q1_rdy || cdb_hit(alloc_q1);
    base_val = alloc_q1_rdy ? alloc_v1 : cdb_val(alloc_q1);
    data_rdy = !alloc_store || alloc_q2_rdy || cdb_hit(alloc_q2);
    data_val = alloc_q2_rdy ? alloc_v2 : cdb_val(alloc_q2);
  end

  logic mmio_ok;
`ifdef LSQ_MMIO_STRICT_EN
  assign mmio_ok = (e_addr[head] < XLEN'(MMIO_BASE)) ||
                   ((e_id[head] == rob_head_id) && !io_full);
`else
  assign mmio_ok = 1'b1;
  logic unused_mmio;
  assign unused_mmio = &{1'b0, rob_head_id, io_full, MMIO_BASE};
`endif

  logic load_go, store_go, issue, alloc_fire;

  assign head_valid  = e_valid[head];
  assign head_store  = e_store[head];
  assign head_id     = e_id[head];
  assign head_ready  = e_addr_rdy[head] && (!e_store[head] || e_data_rdy[head]);
  assign full        = (count == CW'(DEPTH));
  assign empty       = (count == '0);
  assign alloc_ready = !full;

  assign load_go    = head_valid && !e_store[head] && e_addr_rdy[head] && mem_ready && mmio_ok;
  assign store_go   = head_valid && e_store[head] && head_ready && commit_store;
  assign issue      = load_go || store_go;
  assign alloc_fire = alloc_valid && !full && !flush;

  // Queue state, wakeup, allocation and the registered memory request.
  always_ff @(posedge clk) begin
    if (rst) begin
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      e_valid        <= '0;
      mem_req_valid  <= 1'b0;
      mem_req_store  <= 1'b0;
      mem_req_funct3 <= '0;
      mem_req_addr   <= '0;
      mem_req_data   <= '0;
      mem_req_id     <= '0;
    end else if (rdy) begin
      if (flush) begin
        e_valid       <= '0;
        count         <= '0;
        tail          <= head;
        mem_req_valid <= 1'b0;
      end else begin
        mem_req_valid <= issue;
        if (issue) begin
          mem_req_store  <= e_store[head];
          mem_req_funct3 <= e_funct3[head];
          mem_req_addr   <= e_addr[head];
          mem_req_data   <= e_store[head] ? e_data[head] : '0;
          mem_req_id     <= e_id[head];
          e_valid[head]  <= 1'b0;
          head           <= head + 1'b1;
        end
        for (int i = 0; i < DEPTH; i++) begin
          if (e_valid[i] && !e_addr_rdy[i] && w1_hit[i]) begin
            e_addr_rdy[i] <= 1'b1;
            e_addr[i]     <= w1_data[i] + e_imm[i];
          end
          if (e_valid[i] && !e_data_rdy[i] && w2_hit[i]) begin
            e_data_rdy[i] <= 1'b1;
            e_data[i]     <= w2_data[i];
          end
        end
        if (alloc_fire) begin
          e_valid[tail]    <= 1'b1;
          e_store[tail]    <= alloc_store;
          e_funct3[tail]   <= alloc_funct3;
          e_id[tail]       <= alloc_rob_id;
          e_q1[tail]       <= alloc_q1;
          e_q2[tail]       <= alloc_q2;
          e_imm[tail]      <= alloc_imm;
          e_addr_rdy[tail] <= base_rdy;
          e_addr[tail]     <= base_val + alloc_imm;
          e_data_rdy[tail] <= data_rdy;
          e_data[tail]     <= data_val;
          tail             <= tail + 1'b1;
        end
        count <= count + CW'(alloc_fire) - CW'(issue);
      end
    end
  end

endmodule

// File: doc/load_store_queue.md
LOAD_STORE_QUEUE -- requirements
Module: load_store_queue

Interface
REQ-001 Parameter DEPTH, default 8: entry count; power of 2, at least 2; all DEPTH entries usable.
REQ-002 Parameter CDB_N, default 2: number of result-broadcast channels.
REQ-003 Parameter XLEN, default 32, data width; ROB_W, default 4, ROB tag width; MMIO_BASE, default 32'h30000.
REQ-004 clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-005 rdy  in  1  global enable, state frozen when low; flush  in  1  mispredict squash.
REQ-006 alloc_valid  in  1  new memory op; alloc_ready  out  1  equals !full.
REQ-007 alloc_store  in  1  store=1/load=0; alloc_funct3  in  3  RISC-V size/sign code; alloc_rob_id  in  ROB_W  tag.
REQ-008 alloc_q1_rdy / alloc_q2_rdy  in  1 each  operand valid; alloc_q1 / alloc_q2  in  ROB_W each  producer tag; alloc_v1 / alloc_v2  in  XLEN each  value; alloc_imm  in  XLEN.
REQ-009 cdb_valid  in  CDB_N; cdb_tag  in  CDB_N*ROB_W; cdb_data  in  CDB_N*XLEN; channel k in slice k.
REQ-010 commit_store  in  1  ROB retires head store; rob_head_id  in  ROB_W; io_full  in  1; mem_ready  in  1.
REQ-011 mem_req_valid  out  1; mem_req_store  out  1; mem_req_funct3  out  3; mem_req_addr  out  XLEN; mem_req_data  out  XLEN; mem_req_id  out  ROB_W; all registered.
REQ-012 head_valid  out  1; head_store  out  1; head_id  out  ROB_W; head_ready  out  1 (address and, for stores, data ready).
REQ-013 full  out  1; empty  out  1; count  out  log2(DEPTH)+1.

Function
REQ-014 Circular queue, head/tail pointers plus count; allocation at tail on the edge where alloc_valid && alloc_ready && !flush.
REQ-015 Address = base + imm, computed at allocation if base ready, else on wakeup; sum truncated to XLEN.
REQ-016 Wakeup: on any cdb_valid[k] with cdb_tag[k] equal to a pending tag, operand captured that edge; if several channels match, lowest k wins.
REQ-017 Same-cycle bypass: operand allocated not-ready whose tag matches a live broadcast is stored ready.
REQ-018 Load issue: head is a load, address ready, mem_ready=1 -> head popped at that edge, mem_req_valid=1 with store=0 in the following cycle.
REQ-019 Store issue: commit_store=1 and head is a ready store -> head popped, mem_req_valid=1 with store=1 and data in the following cycle.
REQ-020 commit_store while head is not a ready store: ignored, no state change.
REQ-021 mem_req_valid is a one-cycle pulse; at most one issue per cycle; payload holds its last value when valid=0.
REQ-022 Allocation and pop in the same cycle: count unchanged. Full blocks allocation even when a pop occurs that cycle.
REQ-023 Pointers wrap modulo DEPTH.
REQ-024 flush: all entries invalidated, count=0, tail=head; mem_req_valid=0 next cycle; flush has priority over allocation, issue and wakeup.
REQ-025 rdy=0: no state or output register changes.

Reset
REQ-026 rst at clk edge while rdy=1: count=0, head=tail=0, all entries invalid, mem_req_valid=0, mem_req_* payload=0.
REQ-027 Reset mid-operation discards all entries and any pending issue; full=0, empty=1 the next cycle.

Configuration
REQ-028 Macro LSQ_MMIO_STRICT_EN defined: a load with address >= MMIO_BASE issues only when head_id==rob_head_id and io_full=0, in addition to REQ-018.
REQ-029 LSQ_MMIO_STRICT_EN undefined: MMIO loads follow REQ-018 only; rob_head_id and io_full are ignored.

Verification
REQ-030 Reset, then allocate 8 loads with DEPTH=8 -> full=1, alloc_ready=0, count=8; 9th alloc_valid is ignored.
REQ-031 Load with base tag 3 not ready, imm=4; cdb channel 1 broadcasts tag 3, data 0x100; mem_ready=1 -> mem_req_valid one cycle later, addr=0x104.
REQ-032 Channels 0 and 1 both broadcast tag 5 (data 0xA vs 0xB) to a pending store-data operand -> stored data=0xA.
REQ-033 Ready store at head, commit_store=1 -> next cycle mem_req_valid=1, store=1, data matches; commit_store asserted with a load at head -> no request.
REQ-034 Queue holds 3 entries; flush in the same cycle as alloc_valid -> count=0, empty=1, no mem_req_valid next cycle.
REQ-035 LSQ_MMIO_STRICT_EN defined: load to 0x30000 with head_id!=rob_head_id -> stalls; rob_head_id matches with io_full=1 -> stalls; io_full=0 -> issues.
